// File: rtl/button_word_capture.sv
// button_word_capture: debounced push-button serial word entry with valid/ready output
module button_word_capture #(
  parameter int DATA_W = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int CW = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              button0,
  input  logic              button1,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [CW-1:0]     bit_count,
  output logic              err_pulse,
  output logic              timeout_pulse
);
  localparam int DW = DEBOUNCE_CYCLES > 0 ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  logic [2:0] pin, filt_q, filt_d, rel_q;
  logic [2:0][SYNC_STAGES-1:0] sync_q;
  logic [2:0][DW-1:0] db_q, db_d;
  logic rs, r0, r1, err_q, err_d, to_q, to_d;
  state_t state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d, out_data_q, out_data_d, shifted;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  assign pin = {button1, button0, start};
  assign {r1, r0, rs} = rel_q;
  assign shifted = MSB_FIRST != 0 ? {sh_q[DATA_W-2:0], r1} : {r1, sh_q[DATA_W-1:1]};
  assign out_data = out_data_q;
  assign out_valid = state_q == HOLD;
  assign busy = state_q != IDLE;
  assign bit_count = cnt_q;
  assign err_pulse = err_q;
  assign timeout_pulse = to_q;
  // filtered level flips once the synced value has disagreed for DEBOUNCE_CYCLES cycles in a row
  always_comb begin
    db_d = '0;
    filt_d = filt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync_q[i][SYNC_STAGES-1] != filt_q[i]) begin
        if (32'(db_q[i]) == DEBOUNCE_CYCLES) filt_d[i] = sync_q[i][SYNC_STAGES-1];
        else db_d[i] = db_q[i] + 1'b1;
      end
    end
  end
  // synchronisers, debounce state and one-cycle release events
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      db_q <= '0;
      filt_q <= '0;
      rel_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pin[i]};
      db_q <= db_d;
      filt_q <= filt_d;
      rel_q <= filt_q & ~filt_d;
    end
  end
  // frame control: start restarts, bit events shift, full word parks in HOLD until accepted
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    out_data_d = out_data_q;
    cnt_d = cnt_q;
    tmr_d = '0;
    err_d = 1'b0;
    to_d = 1'b0;
    case (state_q)
      IDLE: if (rs) begin
        state_d = COLLECT;
        sh_d = '0;
        cnt_d = '0;
      end
      COLLECT: begin
        tmr_d = TIMEOUT_CYCLES > 0 ? tmr_q + 1'b1 : '0;
        if (rs) begin
          sh_d = '0;
          cnt_d = '0;
          tmr_d = '0;
        end else if (r0 && r1) begin
          err_d = 1'b1;
          tmr_d = tmr_q;
        end else if (r0 || r1) begin
          sh_d = shifted;
          tmr_d = '0;
          if (32'(cnt_q) == DATA_W - 1) begin
            out_data_d = shifted;
            cnt_d = '0;
            state_d = HOLD;
          end else cnt_d = cnt_q + 1'b1;
        end else if (TIMEOUT_CYCLES > 0 && 32'(tmr_q) == TIMEOUT_CYCLES - 1) begin
          state_d = IDLE;
          cnt_d = '0;
          to_d = 1'b1;
        end
      end
      HOLD: if (out_ready) begin
        state_d = rs ? COLLECT : IDLE;
        sh_d = '0;
        cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // frame state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q <= '0;
      out_data_q <= '0;
      cnt_q <= '0;
      tmr_q <= '0;
      err_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      out_data_q <= out_data_d;
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
      err_q <= err_d;
      to_q <= to_d;
    end
  end
endmodule
